// File: rtl/output_device_serial_tx.sv
// Output-device write port that queues 32-bit words in a FIFO and sends each one LSB-byte-first
// as four 8N1 frames on tx. FIFO level, busy and overflow can be read back on a status port.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (tx low) of byte byte_idx
// DATA  | data bit bit_idx of byte byte_idx, LSB first
// STOP  | stop bit (tx high); chains to next byte or next word
module output_device_serial_tx #(
  parameter logic [7:0] DEVICE_ADDR = 8'h02,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         BAUD_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  input  logic [31:0] value,
  input  logic        is_write,
  input  logic [7:0]  status_address,
  output logic [31:0] status_value,
  output logic        tx,
  output logic        busy
);

  localparam int              PW         = $clog2(FIFO_DEPTH);
  localparam int              BW         = $clog2(BAUD_DIV);
  localparam logic [7:0]      CTRL_ADDR  = DEVICE_ADDR + 8'd1;
  localparam logic [4:0]      FULL_COUNT = 5'(FIFO_DEPTH);
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]   BAUD_ONE   = BW'(1);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic [31:0]   shift_word;
  logic [1:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [2:0]    next_bit;
  logic [BW-1:0] baud_cnt;
  logic          baud_last, fifo_empty, fifo_full;
  logic          data_wr, ctrl_clr, pop, push;

  assign baud_last  = (baud_cnt == BAUD_LAST);
  assign fifo_empty = (count == 5'd0);
  assign fifo_full  = (count == FULL_COUNT);
  assign data_wr    = is_write && (address == DEVICE_ADDR);
  assign ctrl_clr   = is_write && (address == CTRL_ADDR) && value[0];
  assign next_bit   = bit_idx + 3'd1;

  // Pop on the IDLE edge, or at the end of the last stop bit for a gapless next word.
  assign pop  = !fifo_empty &&
                ((state == IDLE) || (state == STOP && baud_last && byte_idx == 2'd3));
  assign push = data_wr && (!fifo_full || pop);

  assign busy = (state != IDLE) || !fifo_empty;
  assign status_value = (status_address == DEVICE_ADDR) ?
                        {overflow, 22'd0, busy, 3'd0, count} : 32'd0;

  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= value;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= 5'd0;
      overflow   <= 1'b0;
      shift_word <= 32'd0;
      byte_idx   <= 2'd0;
      bit_idx    <= 3'd0;
      baud_cnt   <= '0;
      tx         <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase

      if (ctrl_clr)                            overflow <= 1'b0;
      else if (data_wr && fifo_full && !pop)   overflow <= 1'b1;

      baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_ONE;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_word <= mem[rd_ptr];
            byte_idx   <= 2'd0;
            tx         <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud_last) begin
            bit_idx <= 3'd0;
            tx      <= shift_word[{byte_idx, 3'd0}];
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx      <= shift_word[{byte_idx, next_bit}];
            end
          end
        end
        STOP: begin
          if (baud_last) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end else if (pop) begin
              shift_word <= mem[rd_ptr];
              byte_idx   <= 2'd0;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_device_serial_tx.sv
// Bench for output_device_serial_tx: directed writes queue expected bytes; a UART receiver
// process decodes the tx line and compares each received byte against the queue.
module tb_output_device_serial_tx;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] value = 32'h0;
  logic        is_write = 1'b0;
  logic [7:0]  status_address = 8'h02;
  logic [31:0] status_value;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  output_device_serial_tx #(
    .DEVICE_ADDR(8'h02),
    .FIFO_DEPTH (4),
    .BAUD_DIV   (B)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .value         (value),
    .is_write      (is_write),
    .status_address(status_address),
    .status_value  (status_value),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART receiver; a frame in progress is dropped whenever reset is seen.
  bit         rx_active = 0;
  int         rx_n = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1;
        rx_n = 0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_n++;
      if (rx_n % B == 1 && rx_n > B && rx_n < 9 * B)
        rx_byte = {tx, rx_byte[7:1]};
      if (rx_n == 9 * B + 1) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=%h required=none", rx_byte);
        end else begin
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
        rx_active = 0;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Called at posedge+2; returns at posedge+2 after write edge E.
  task automatic do_write(input logic [7:0] a, input logic [31:0] v);
    address  = a;
    value    = v;
    is_write = 1'b1;
    @(posedge clk);
    #2;
    is_write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_status", status_value, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
    repeat (2 * B) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int tx_low;
    @(posedge clk);
    #2;
    do_reset();

    // Single word: exact start-bit, first data bit and busy-fall timing.
    push_word(32'h0000_00A5);
    do_write(8'h02, 32'h0000_00A5);
    @(negedge clk);
    chk("sw_status_E", status_value, 32'h0000_0101);
    chk("sw_tx_E", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("sw_tx_E1", {31'd0, tx}, 32'd0);
    chk("sw_status_E1", status_value, 32'h0000_0100);
    repeat (3) @(negedge clk);
    chk("sw_tx_E4", {31'd0, tx}, 32'd0);
    @(negedge clk);
    chk("sw_tx_E5", {31'd0, tx}, 32'd1);
    repeat (155) @(negedge clk);
    chk("sw_busy_E160", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("sw_busy_E161", {31'd0, busy}, 32'd0);
    chk("sw_tx_E161", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #2;
    drain(50);
    do_reset();

    // Back-to-back words: eight contiguous frames.
    start_q.delete();
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    do_write(8'h02, 32'h1122_3344);
    do_write(8'h02, 32'h5566_7788);
    drain(400);
    chk("b2b_frames", start_q.size(), 32'd8);
    bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 10 * B) bad++;
    chk("b2b_gaps", bad, 32'd0);
    if (start_q.size() == 8)
      chk("b2b_span", start_q[7] - start_q[0], 70 * B);
    do_reset();

    // Overflow: W0 popped, W1..W4 queued, W5 dropped.
    for (int i = 0; i < 5; i++) push_word(32'h0101_0101 * (i + 1));
    for (int i = 0; i < 6; i++) do_write(8'h02, 32'h0101_0101 * (i + 1));
    @(negedge clk);
    chk("ovf_status", status_value, 32'h8000_0104);
    @(posedge clk);
    #2;
    do_write(8'h03, 32'h0000_0002);
    @(negedge clk);
    chk("ovf_ctrl_bit1", status_value, 32'h8000_0104);
    @(posedge clk);
    #2;
    do_write(8'h03, 32'h0000_0001);
    @(negedge clk);
    chk("ovf_cleared", status_value, 32'h0000_0104);
    @(posedge clk);
    #2;
    drain(1000);
    do_reset();

    // Push on the exact edge the FSM pops while full (E0+161).
    for (int i = 0; i < 6; i++) push_word(32'hA0B0_C000 + i);
    for (int i = 0; i < 5; i++) do_write(8'h02, 32'hA0B0_C000 + i);
    @(negedge clk);
    chk("pp_full", status_value, 32'h0000_0104);
    repeat (156) @(posedge clk);
    #2;
    chk("pp_pre", status_value, 32'h0000_0104);
    do_write(8'h02, 32'hA0B0_C005);
    @(negedge clk);
    chk("pp_post", status_value, 32'h0000_0104);
    @(posedge clk);
    #2;
    drain(1200);
    do_reset();

    // Reset during a data bit abandons the frame; next word sends normally.
    do_write(8'h02, 32'hDEAD_BEEF);
    repeat (8) @(posedge clk);
    #2;
    chk("mr_in_frame", {31'd0, busy}, 32'd1);
    do_reset();
    push_word(32'h0000_005A);
    do_write(8'h02, 32'h0000_005A);
    drain(300);
    do_reset();

    // Address decode.
    do_write(8'h04, 32'h0000_00FF);
    @(negedge clk);
    chk("ad_no_push", status_value, 32'h0);
    tx_low = 0;
    repeat (3 * B) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    chk("ad_tx_idle", tx_low, 32'd0);
    @(posedge clk);
    #2;
    push_word(32'h1234_5678);
    do_write(8'h02, 32'h1234_5678);
    @(negedge clk);
    status_address = 8'h03;
    #1 chk("ad_status_03", status_value, 32'h0);
    status_address = 8'h00;
    #1 chk("ad_status_00", status_value, 32'h0);
    status_address = 8'h02;
    #1 chk("ad_status_02", status_value, 32'h0000_0101);
    @(posedge clk);
    #2;
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
